// File: rtl/spi_master_rx_if.sv
// rtl/spi_master_rx_if.sv - received-word stream between spi_master_rx and its consumer
interface spi_master_rx_if;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        data_last_o;
  logic        data_ready_i;

  modport master (
    output data_o,
    output data_valid_o,
    output data_last_o,
    input  data_ready_i
  );

  modport slave (
    input  data_o,
    input  data_valid_o,
    input  data_last_o,
    output data_ready_i
  );
endinterface

// File: rtl/spi_master_rx.sv
// rtl/spi_master_rx.sv - SPI mode-0 receive-only master delivering 32-bit words
module spi_master_rx #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [7:0]       len_i,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic             spi_sdi_i,
  output logic             spi_clk_o,
  output logic             spi_cs_no,
  output logic             busy_o,
  output logic             done_o,
  spi_master_rx_if.master  rx_if
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_HIGH, S_LOW, S_TRAIL
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] hcnt_q, hcnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       len_q, len_d;
  logic [8:0]       bit_cnt_q, bit_cnt_d;
  logic [31:0]      sh_q, sh_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  logic half_end;
  logic last_bit;
  logic word_end;
  logic can_move;
  logic at_word_end;
  logic stall;
  logic move;

  // Phase and word-boundary decode shared by the FSM and the datapath
  always_comb begin
    half_end    = (hcnt_q == div_q);
    last_bit    = (bit_cnt_q == ({1'b0, len_q} + 9'd1));
    word_end    = last_bit || (bit_cnt_q[4:0] == 5'd0);
    can_move    = !valid_q || rx_if.data_ready_i;
    at_word_end = (state_q == S_HIGH) && half_end && word_end;
    stall       = at_word_end && !can_move;
    move        = at_word_end && can_move;
  end

  // State and datapath registers; reset aborts any transfer and drops pending words
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      div_q     <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      div_q     <= div_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  // Next state: each non-idle phase lasts one half period; HIGH stretches while the output is blocked
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_LEAD;
      S_LEAD:  if (half_end) state_d = S_HIGH;
      S_HIGH:  if (half_end && !stall) state_d = last_bit ? S_TRAIL : S_LOW;
      S_LOW:   if (half_end) state_d = S_HIGH;
      S_TRAIL: if (half_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch parameters at start, time half periods, shift on SCLK rise, hand words off
  always_comb begin
    hcnt_d    = hcnt_q;
    div_d     = div_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = (state_q == S_TRAIL) && half_end;

    if (state_q == S_IDLE) begin
      if (start_i) begin
        len_d     = len_i;
        div_d     = clk_div_i;
        hcnt_d    = '0;
        bit_cnt_d = '0;
        sh_d      = '0;
      end
    end else if (half_end) begin
      if (!stall) hcnt_d = '0;
    end else begin
      hcnt_d = hcnt_q + DIV_W'(1);
    end

    if ((state_d == S_HIGH) && (state_q != S_HIGH)) begin
      sh_d      = {sh_q[30:0], spi_sdi_i};
      bit_cnt_d = bit_cnt_q + 9'd1;
    end

    if (valid_q && rx_if.data_ready_i) valid_d = 1'b0;

    // Clearing the shift register after a hand-off zero-extends a short final word
    if (move) begin
      data_d  = sh_q;
      last_d  = last_bit;
      valid_d = 1'b1;
      sh_d    = '0;
    end
  end

  // Outputs decoded from the registered state so reset takes effect immediately
  always_comb begin
    spi_clk_o          = (state_q == S_HIGH);
    spi_cs_no          = (state_q == S_IDLE);
    busy_o             = (state_q != S_IDLE);
    done_o             = done_q;
    rx_if.data_o       = data_q;
    rx_if.data_valid_o = valid_q;
    rx_if.data_last_o  = last_q;
  end

endmodule

// File: tb/tb_spi_master_rx.sv
// tb/tb_spi_master_rx.sv - directed self-checking bench for spi_master_rx
module tb_spi_master_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic [7:0] div = '0;
  logic       sdi;
  logic       spi_clk, cs_n, busy, done;
  logic [255:0] tx_vec = '0;

  spi_master_rx_if rx_if();

  spi_master_rx #(.DIV_W(8)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .len_i     (len),
    .clk_div_i (div),
    .spi_sdi_i (sdi),
    .spi_clk_o (spi_clk),
    .spi_cs_no (cs_n),
    .busy_o    (busy),
    .done_o    (done),
    .rx_if     (rx_if.slave)
  );

  always #5 clk = ~clk;

  // Slave model: MSB first, next bit presented on each SCLK fall
  assign sdi = tx_vec[255];
  always @(negedge spi_clk) tx_vec = tx_vec << 1;

  int      n_chk = 0;
  int      n_pass = 0;
  int      rises = 0;
  int      done_cnt = 0;
  time     rise_t = 0;
  time     per_min, per_max, hi_min, hi_max;
  bit      have_rise = 0;
  logic [31:0] got_w[$];
  logic        got_l[$];

  always @(posedge spi_clk) begin
    if (have_rise) begin
      if ($time - rise_t < per_min) per_min = $time - rise_t;
      if ($time - rise_t > per_max) per_max = $time - rise_t;
    end
    rise_t = $time;
    have_rise = 1;
    rises++;
  end

  always @(negedge spi_clk) begin
    if (have_rise) begin
      if ($time - rise_t < hi_min) hi_min = $time - rise_t;
      if ($time - rise_t > hi_max) hi_max = $time - rise_t;
    end
  end

  always @(negedge clk) begin
    if (rst_n && rx_if.data_valid_o && rx_if.data_ready_i) begin
      got_w.push_back(rx_if.data_o);
      got_l.push_back(rx_if.data_last_o);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic start_xfer(input logic [7:0] l, input logic [7:0] d, input logic [255:0] v);
    @(posedge clk); #1;
    tx_vec = v;
    rises = 0; have_rise = 0;
    per_min = 1000000; per_max = 0; hi_min = 1000000; hi_max = 0;
    got_w.delete(); got_l.delete();
    len = l; div = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin
        repeat (3) @(negedge clk);
        return;
      end
    end
    chk(tag, 0, 1);
  endtask

  task automatic wait_rises(input int n, input string tag);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (rises >= n) return;
    end
    chk(tag, 0, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cs"}, cs_n, 1);
    chk({tag, "_sclk"}, spi_clk, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, rx_if.data_valid_o, 0);
  endtask

  int d0;

  initial begin
    rx_if.data_ready_i = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("rst");
    chk("rst_data", rx_if.data_o, 0);
    chk("rst_last", rx_if.data_last_o, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    // len=7, div=0, 0xA5
    start_xfer(8'd7, 8'd0, {8'hA5, 248'h0});
    wait_done("a5_timeout");
    chk("a5_words", got_w.size(), 1);
    chk("a5_data", got_w.size() > 0 ? got_w[0] : 32'hx, 32'h000000A5);
    chk("a5_last", got_w.size() > 0 ? got_l[0] : 1'bx, 1);
    chk("a5_rises", rises, 8);
    chk("a5_per_min", per_min, 20);
    chk("a5_per_max", per_max, 20);
    chk("a5_hi", hi_max, 10);
    chk("a5_done", done_cnt, 1);
    chk_idle("a5_end");

    // len=63, div=3, two words
    start_xfer(8'd63, 8'd3, {32'hDEADBEEF, 32'h12345678, 192'h0});
    wait_done("two_timeout");
    chk("two_words", got_w.size(), 2);
    chk("two_w0", got_w.size() > 0 ? got_w[0] : 32'hx, 32'hDEADBEEF);
    chk("two_l0", got_w.size() > 0 ? got_l[0] : 1'bx, 0);
    chk("two_w1", got_w.size() > 1 ? got_w[1] : 32'hx, 32'h12345678);
    chk("two_l1", got_w.size() > 1 ? got_l[1] : 1'bx, 1);
    chk("two_rises", rises, 64);
    chk("two_per", per_max, 80);
    chk("two_per_min", per_min, 80);
    chk("two_hi", hi_min, 40);
    chk("two_done", done_cnt, 2);

    // Backpressure: first word unconsumed holds SCLK high after bit 64
    rx_if.data_ready_i = 1'b0;
    start_xfer(8'd63, 8'd0, {32'hCAFEF00D, 32'h0BADC0DE, 192'h0});
    wait_rises(64, "bp_rise_timeout");
    repeat (20) @(negedge clk);
    chk("bp_sclk_held", spi_clk, 1);
    chk("bp_busy", busy, 1);
    chk("bp_valid", rx_if.data_valid_o, 1);
    chk("bp_pending", rx_if.data_o, 32'hCAFEF00D);
    chk("bp_no_done", done_cnt, 2);
    @(posedge clk); #1;
    rx_if.data_ready_i = 1'b1;
    wait_done("bp_timeout");
    chk("bp_words", got_w.size(), 2);
    chk("bp_w0", got_w.size() > 0 ? got_w[0] : 32'hx, 32'hCAFEF00D);
    chk("bp_w1", got_w.size() > 1 ? got_w[1] : 32'hx, 32'h0BADC0DE);
    chk("bp_l1", got_w.size() > 1 ? got_l[1] : 1'bx, 1);
    chk("bp_rises", rises, 64);

    // len=39, partial final word zero-extended
    start_xfer(8'd39, 8'd1, {256{1'b1}});
    wait_done("part_timeout");
    chk("part_words", got_w.size(), 2);
    chk("part_w0", got_w.size() > 0 ? got_w[0] : 32'hx, 32'hFFFFFFFF);
    chk("part_l0", got_w.size() > 0 ? got_l[0] : 1'bx, 0);
    chk("part_w1", got_w.size() > 1 ? got_w[1] : 32'hx, 32'h000000FF);
    chk("part_l1", got_w.size() > 1 ? got_l[1] : 1'bx, 1);
    chk("part_rises", rises, 40);

    // Reset at bit 10 of len=31
    d0 = done_cnt;
    start_xfer(8'd31, 8'd1, {32'hFFFF0000, 224'h0});
    wait_rises(10, "mid_rise_timeout");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_data", rx_if.data_o, 0);
    repeat (3) @(negedge clk);
    chk("mid_no_done", done_cnt, d0);
    chk("mid_no_word", got_w.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_xfer(8'd31, 8'd0, {32'h13579BDF, 224'h0});
    wait_done("after_rst_timeout");
    chk("after_rst_words", got_w.size(), 1);
    chk("after_rst_w0", got_w.size() > 0 ? got_w[0] : 32'hx, 32'h13579BDF);
    chk("after_rst_l0", got_w.size() > 0 ? got_l[0] : 1'bx, 1);
    chk("after_rst_done", done_cnt, d0 + 1);

    // start while busy is ignored
    start_xfer(8'd15, 8'd1, {16'hBEEF, 240'h0});
    repeat (5) @(posedge clk);
    #1;
    len = 8'd3; div = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_timeout");
    chk("busy_rises", rises, 16);
    chk("busy_per", per_max, 40);
    chk("busy_per_min", per_min, 40);
    chk("busy_words", got_w.size(), 1);
    chk("busy_w0", got_w.size() > 0 ? got_w[0] : 32'hx, 32'h0000BEEF);
    chk("busy_done", done_cnt, d0 + 2);
    chk_idle("busy_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
